// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator.
// Drives pc_q onto an async-read instruction memory, captures {pc, inst}
// into a small prefetch FIFO and presents the head entry to decode over a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
// Optional build macro FETCH_PERF_EN adds fetch and redirect event counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Handshake decode and head outputs; storage is masked while nothing is valid.
    always_comb begin
        imem_pc   = pc_q;
        dec_valid = (count != '0) & ~redirect_valid;
        pop       = dec_valid & dec_ready;
        push      = ~redirect_valid & ((count < DEPTH_C) | pop);
        dec_pc    = dec_valid ? fifo_pc[rd_ptr]   : 32'h0;
        dec_inst  = dec_valid ? fifo_inst[rd_ptr] : 32'h0;
    end

    // PC, pointers and occupancy; reset beats redirect, redirect beats the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc_q   <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc_q   <= pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: it is only visible behind dec_valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc[wr_ptr]   <= pc_q;
            fifo_inst[wr_ptr] <= imem_inst;
        end
    end

`ifdef FETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'h0;
            perf_redirect_cnt <= 32'h0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
